// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants: FSM encodings, reset defaults and RV32I opcodes.
// Decode and imm_gen import the opcode constants from here.
package fetch_pkg;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// RV32I fetch: owns the PC, one outstanding imem request, IF/ID register; response lands in id_* the edge it arrives.
// A request is only raised when the IF/ID slot is free, so a stalled decode stops fetch; redirects flush everything.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  logic [31:0] pc;
  logic [31:0] pc_inflight;
  logic [1:0]  state;
  logic        slot_free;
  logic        req_fire;
  logic        capture;

  assign slot_free      = !id_valid || id_ready;
  assign imem_req_valid = (state == S_REQ) && slot_free && !redirect_valid;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign capture        = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= word_align(RESET_PC);
      pc_inflight <= '0;
      state       <= S_REQ;
    end else if (redirect_valid) begin
      pc <= word_align(redirect_pc);
      // A fetch still in flight must be drained before the target can be requested.
      if ((state == S_WAIT || state == S_DROP) && !imem_rsp_valid) begin
        state <= S_DROP;
      end else begin
        state <= S_REQ;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (req_fire) begin
            pc_inflight <= pc;
            pc          <= pc + 32'd4;
            state       <= S_WAIT;
          end
        end
        S_WAIT, S_DROP: begin
          if (imem_rsp_valid) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid    <= 1'b0;
      id_inst     <= NOP_INST;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
    end else if (redirect_valid) begin
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
    end else if (capture) begin
      id_valid    <= 1'b1;
      id_inst     <= imem_rsp_data;
      id_pc       <= pc_inflight;
      id_pc_plus4 <= pc_inflight + 32'd4;
    end else if (id_ready) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scoreboarded request and IF/ID handshakes plus direct cycle checks.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc_plus4;
  } id_exp_t;

  logic [31:0] exp_req[$];
  id_exp_t     exp_id[$];

  int n_chk  = 0;
  int n_fail = 0;

  int          cyc = 0;
  int          mem_lat = 1;
  logic        inject = 1'b0;
  logic        pend = 1'b0;
  int          pend_due = 0;
  logic [31:0] pend_addr = '0;
  logic        tput = 1'b0;
  logic        have_prev = 1'b0;
  int          prev_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_id(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] p4);
    id_exp_t e;
    e.pc = pc;
    e.inst = inst;
    e.pc_plus4 = p4;
    exp_id.push_back(e);
  endtask

  // Memory model: instruction word at addr is {addr[29:0], 2'b11}.
  always begin
    @(posedge clk);
    #2;
    cyc++;
    if (inject) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else if (pend && pend_due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = {pend_addr[29:0], 2'b11};
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (imem_rsp_valid) pend = 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        pend      = 1'b1;
        pend_addr = imem_req_addr;
        pend_due  = cyc + mem_lat;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && imem_req_valid && imem_req_ready) begin
      if (exp_req.size() == 0) begin
        check("unexpected_req", imem_req_addr, 32'hFFFF_FFFF);
      end else begin
        check("req_addr", imem_req_addr, exp_req.pop_front());
      end
      if (tput && have_prev) check("req_spacing", 32'(cyc - prev_cyc), 32'd2);
      prev_cyc  = cyc;
      have_prev = 1'b1;
    end
    if (rst_n && id_valid && id_ready) begin
      if (exp_id.size() == 0) begin
        check("unexpected_id", id_pc, 32'hFFFF_FFFF);
      end else begin
        id_exp_t e;
        e = exp_id.pop_front();
        check("id_pc", id_pc, e.pc);
        check("id_inst", id_inst, e.inst);
        check("id_pc_plus4", id_pc_plus4, e.pc_plus4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    imem_req_ready = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_id_valid", {31'b0, id_valid}, 32'd0);
    check("rst_id_inst", id_inst, 32'h0000_0013);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_pc_plus4", id_pc_plus4, 32'd0);

    // Streaming from RESET_PC with a 1-cycle memory.
    tick();
    exp_req.push_back(32'h100);
    exp_req.push_back(32'h104);
    exp_req.push_back(32'h108);
    exp_req.push_back(32'h10C);
    push_id(32'h100, 32'h403, 32'h104);
    push_id(32'h104, 32'h413, 32'h108);
    push_id(32'h108, 32'h423, 32'h10C);
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    tput = 1'b1;
    repeat (6) tick();

    // Decode stall holds the register and blocks fetch.
    tput = 1'b0;
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, id_valid}, 32'd1);
      check("hold_inst", id_inst, 32'h423);
      check("hold_pc", id_pc, 32'h108);
      check("hold_pc_plus4", id_pc_plus4, 32'h10C);
      check("hold_req_valid", {31'b0, imem_req_valid}, 32'd0);
      tick();
    end
    id_ready = 1'b1;
    mem_lat = 3;
    @(negedge clk);
    check("release_req_valid", {31'b0, imem_req_valid}, 32'd1);

    // Redirect while the 0x10C fetch is outstanding.
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2003;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("drop_id_valid", {31'b0, id_valid}, 32'd0);
    check("drop_id_inst", id_inst, 32'h13);
    check("drop_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    @(negedge clk);
    check("stale_rsp_id_valid", {31'b0, id_valid}, 32'd0);
    check("stale_rsp_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    mem_lat = 1;
    exp_req.push_back(32'h2000);
    exp_req.push_back(32'h2004);
    push_id(32'h2000, 32'h8003, 32'h2004);
    @(negedge clk);
    check("target_id_valid", {31'b0, id_valid}, 32'd0);
    check("target_id_inst", id_inst, 32'h13);
    repeat (3) tick();

    // Redirect coincident with the 0x2004 response, to the top word of memory.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0000_0000);
    exp_req.push_back(32'h0000_0004);
    push_id(32'hFFFF_FFFC, 32'hFFFF_FFF3, 32'h0000_0000);
    push_id(32'h0000_0000, 32'h0000_0003, 32'h0000_0004);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("same_cycle_id_valid", {31'b0, id_valid}, 32'd0);
    repeat (4) tick();

    // Park in S_DROP, then reset asynchronously.
    mem_lat = 5;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("sdrop_req_valid", {31'b0, imem_req_valid}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_id_valid", {31'b0, id_valid}, 32'd0);
    check("arst_id_inst", id_inst, 32'h13);
    check("arst_id_pc", id_pc, 32'd0);
    check("arst_id_pc_plus4", id_pc_plus4, 32'd0);
    check("arst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("arst_req_addr", imem_req_addr, 32'h100);
    repeat (2) tick();
    imem_req_ready = 1'b0;
    mem_lat = 1;
    tick();
    rst_n = 1'b1;
    #1 inject = 1'b1;
    tick();
    inject = 1'b0;
    @(negedge clk);
    check("sreq_rsp_ignored", {31'b0, id_valid}, 32'd0);
    tick();
    imem_req_ready = 1'b1;
    exp_req.push_back(32'h100);
    push_id(32'h100, 32'h403, 32'h104);
    repeat (2) tick();
    imem_req_ready = 1'b0;
    repeat (4) tick();
    check("req_queue_drained", 32'(exp_req.size()), 32'd0);
    check("id_queue_drained", 32'(exp_id.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the RV32I core: owns the PC, issues word fetches to instruction memory over a valid/ready request channel with one outstanding request, and captures each returned instruction into the IF/ID output register. Decode and the immediate generator consume that register. A redirect from execute (taken branch, jal, jalr) flushes the output register and any in-flight fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- NOP_INST, 32'h0000_0013, value loaded into id_inst on reset and on flush (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
- imem_rsp_valid  input  1  response valid; memory cannot be back-pressured, and a response arrives ≥1 cycle after its request handshake.
- imem_rsp_data  input  32  instruction word.
- redirect_valid  input  1  redirect PC this cycle.
- redirect_pc  input  32  target; bits [1:0] ignored, forced to 0.
- id_valid  output  1  IF/ID register holds a valid instruction.
- id_ready  input  1  decode consumes the register this cycle.
- id_inst  output  32  instruction.
- id_pc  output  32  address of id_inst.
- id_pc_plus4  output  32  id_pc + 4, modulo 2^32.

## Operation
- Registers: pc (next address to fetch), pc_inflight (address of outstanding request), state, IF/ID output register.
- States: S_REQ, S_WAIT, S_DROP. Reset enters S_REQ.
- slot_free = !id_valid || id_ready.
- imem_req_valid = (state == S_REQ) && slot_free && !redirect_valid. This is combinational from id_ready and redirect_valid. imem_req_addr = pc.
- S_REQ, request handshake: pc_inflight <= pc, pc <= pc + 4 (wraps at 2^32), go to S_WAIT.
- S_WAIT, imem_rsp_valid and no redirect: load id_inst <= imem_rsp_data, id_pc <= pc_inflight, id_pc_plus4 <= pc_inflight + 4, id_valid <= 1. Go to S_REQ.
- S_WAIT, redirect with no response that cycle: go to S_DROP. Redirect and response in the same cycle: discard the response and go to S_REQ.
- S_DROP: wait for imem_rsp_valid, discard the data, go to S_REQ. A further redirect in S_DROP updates pc and stays in S_DROP.
- Any redirect, any state: pc <= {redirect_pc[31:2], 2'b00}; id_valid <= 0; id_inst <= NOP_INST. Redirect takes priority over consumption and capture.
- id_ready with id_valid and no capture: id_valid <= 0.
- Hold: while id_valid && !id_ready, all id_* outputs stay stable.
- Capture into the slot needs no space check. A request is issued only when slot_free, so the slot is empty when the response arrives.
- imem_rsp_valid in S_REQ is a protocol error; it is ignored.

## Timing
- Reset values: pc = RESET_PC, pc_inflight = 0, state = S_REQ, id_valid = 0, id_inst = NOP_INST, id_pc = 0, id_pc_plus4 = 0. imem_req_valid follows the S_REQ equation in the first cycle after reset release.
- Fetch latency: request handshake at edge t, response in cycle t+k (k ≥ 1), id_valid high after edge t+k.
- Peak throughput with a 1-cycle memory and id_ready held high: one instruction every 2 cycles.
- Redirect to new-target request: redirect sampled at edge t, request with the target presented in cycle t+1 (S_REQ case). From S_WAIT, the request waits until the stale response has been discarded.
- Reset asserted mid-operation clears state immediately. A response still in flight after reset release, while in S_REQ, is ignored.

## Structure
- Package fetch_pkg: state enum (S_REQ, S_WAIT, S_DROP), default RESET_PC, NOP_INST constant. Opcode constants are shared with imm_gen and decode.
- Single module. No sub-module is needed; the output register is inline.

## Test plan
- Reset with RESET_PC=0x100, 1-cycle memory, id_ready=1 → requests to 0x100, 0x104, 0x108; id_pc sequence matches; id_pc_plus4 = id_pc+4; throughput 1 every 2 cycles.
- id_ready=0 for 5 cycles with a valid instruction held → id_* stable, imem_req_valid=0; on release, next request is issued in the same cycle as id_ready=1.
- Redirect to 0x2003 in S_WAIT, response 3 cycles later → response discarded, next request addr 0x2000, id_valid=0 with id_inst=0x13 until it returns.
- Redirect in the same cycle as imem_rsp_valid → response dropped, next request at target, no stale id_valid.
- pc=0xFFFF_FFFC fetch → next request addr 0x0000_0000, id_pc_plus4=0x0.
- Reset asserted while in S_DROP → outputs return to reset values asynchronously; fetch restarts at RESET_PC.
